mem_refill_responder: RTL and testbench
=======================================

// Module: mem_refill_responder
// PURPOSE
//  Responder side of the L1 cache miss protocol: accepts line-fetch requests from icache and dcache
//  and single-word store requests from dcache, then drives the backing 1MB user RAM.
//  Streams a refill line back one word per cycle.
//  Sits between the memory subsystem's L1I/L1D and the on-chip RAM; serves one request at a time.
// PARAMETERS
//  ADDR_W          20   byte-address width of user memory (0x00000..0xFFFFF)
//  WORDS_PER_LINE  4    cache line length in 32-bit words; power of 2, >=2
//  IDX_W   $clog2(WORDS_PER_LINE)  word-in-line index width (localparam)
// PORTS
//  CLK_cpu       in   1        CPU clock, all logic on rising edge
//  RST_cpu_n     in   1        asynchronous, active-low reset
//  ic_req        in   1        icache line fetch request; held high until ic_ack
//  ic_addr       in   ADDR_W   icache miss byte address
//  ic_ack        out  1        1-cycle pulse: icache request accepted
//  ic_rsp_valid  out  1        rsp_data holds an icache refill word
//  dc_req        in   1        dcache request (fetch or store); held high until dc_ack
//  dc_we         in   1        1 = single-word store, 0 = line fetch
//  dc_addr       in   ADDR_W   dcache byte address
//  dc_wdata      in   32       store data, lane-aligned
//  dc_wstrb      in   4        store byte enables (0001/0011/1111 shifted by addr[1:0])
//  dc_ack        out  1        1-cycle pulse: dcache request accepted
//  dc_rsp_valid  out  1        rsp_data holds a dcache refill word
//  rsp_data      out  32       refill word (shared by both caches)
//  rsp_word      out  IDX_W    word index of rsp_data within its line
//  rsp_last      out  1        final word of the current burst
//  ram_en        out  1        RAM access strobe
//  ram_we        out  1        RAM write enable
//  ram_wstrb     out  4        RAM byte enables
//  ram_addr      out  ADDR_W-2 RAM word address
//  ram_wdata     out  32       RAM write data
//  ram_rdata     in   32       RAM read data, valid 1 cycle after ram_en&~ram_we
//  busy          out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-burst abandons the transaction; no further
//   rsp_valid; requester re-requests after reset release.
//  FSM: IDLE -> READ (fetch accepted) | WRITE (store accepted); READ -> DRAIN after last ram_en;
//   DRAIN -> IDLE; WRITE -> IDLE.
//  Arbitration in IDLE: dc_req wins over ic_req when both high; loser keeps req high, served next.
//   Fixed priority; no starvation guard.
//  Accept cycle T: ack pulse, latch addr/source/we/wdata/wstrb. No request is sampled outside IDLE.
//  READ: cycles T+1..T+N issue ram_en=1, ram_we=0, ram_addr = line base word + word index
//   (N=WORDS_PER_LINE). Word index counter has IDX_W bits and wraps mod N.
//  Data: cycles T+2..T+N+1 drive rsp_data=ram_rdata, rsp_word=index issued one cycle earlier, and
//   the source's rsp_valid=1. rsp_last=1 on cycle T+N+1 only; FSM back in IDLE at T+N+2.
//  Earliest next accept: T+N+2. Back-to-back fetch occupancy is N+2 cycles.
//  WRITE: cycle T+1 drives ram_en=ram_we=1, ram_addr=dc_addr[ADDR_W-1:2], latched wdata/wstrb.
//   No response beat is produced. IDLE at T+2.
//  ram_en/ram_we/rsp_valid/rsp_last are registered; 0 whenever not explicitly driven.
//  Address bits above ADDR_W are never seen (decode done upstream); addr[1:0] ignored for fetches.
// CONFIGURATION
//  CRITICAL_WORD_FIRST_EN defined: burst starts at word addr[IDX_W+1:2] and wraps to 0 past N-1.
//   Example: N=4, start 2 gives order 2,3,0,1. rsp_last is on the 4th beat.
//  Not defined: burst always starts at word 0 (order 0..N-1); rsp_word equals beat number.
// TESTING
//  1 Reset: RST_cpu_n=0 mid-READ beat 2 -> all outputs 0 next edge; IDLE, no beats after release.
//  2 ic_req, ic_addr=0x00124 (no CWF) -> ic_ack@T; ram_addr 0x48..0x4B @T+1..T+4;
//    ic_rsp_valid @T+2..T+5, last @T+5.
//  3 ic_req and dc_req(fetch 0x00400) same cycle -> dc_ack first, 4 dc beats.
//    ic_ack at T+6 with ic_req still high.
//  4 dc store addr 0x00013, wstrb 1000, wdata 0xAB000000 -> dc_ack@T.
//    ram_we=1, ram_addr 0x4, ram_wstrb 1000 @T+1. No rsp_valid. busy low @T+2.
//  5 CWF: dc fetch 0x0002C -> rsp_word 3,0,1,2; ram_addr 0xB,0x8,0x9,0xA; rsp_last with word 2.
//  6 line at top, ic_addr=0xFFFF0 -> ram_addr 0x3FFFC..0x3FFFF; no carry into the next line.

Source files
------------

// File: rtl/mem_refill_responder_if.sv
// Bus bundle between the L1 caches, the refill responder and the user RAM.
// slave = responder view, master = requester/RAM view.
interface mem_refill_responder_if #(
    parameter int ADDR_W         = 20,
    parameter int WORDS_PER_LINE = 4
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ack;
    logic              ic_rsp_valid;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [31:0]       dc_wdata;
    logic [3:0]        dc_wstrb;
    logic              dc_ack;
    logic              dc_rsp_valid;

    logic [31:0]       rsp_data;
    logic [IDX_W-1:0]  rsp_word;
    logic              rsp_last;

    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_wstrb;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb, ram_rdata,
        output ic_ack, ic_rsp_valid, dc_ack, dc_rsp_valid, rsp_data, rsp_word, rsp_last,
               ram_en, ram_we, ram_wstrb, ram_addr, ram_wdata, busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb, ram_rdata,
        input  ic_ack, ic_rsp_valid, dc_ack, dc_rsp_valid, rsp_data, rsp_word, rsp_last,
               ram_en, ram_we, ram_wstrb, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/mem_refill_responder.sv
// L1 miss responder: one icache/dcache line fetch (N+2 cycles, word beats at T+2..T+N+1) or dcache store (2 cycles) at a time.
// No backpressure on beats; requests wait on held req until IDLE. CRITICAL_WORD_FIRST_EN starts bursts at the missed word.
module mem_refill_responder #(
    parameter int ADDR_W         = 20,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                    CLK_cpu,
    input  logic                    RST_cpu_n,
    mem_refill_responder_if.slave   bus
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_WRITE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_src_dc, w_src_dc_nxt;
    logic [IDX_W-1:0]  r_beat, w_beat_nxt;
    logic              r_ram_en, w_ram_en_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic [3:0]        r_ram_wstrb, w_ram_wstrb_nxt;
    logic [WA_W-1:0]   r_ram_addr, w_ram_addr_nxt;
    logic [31:0]       r_ram_wdata, w_ram_wdata_nxt;
    logic              r_ic_vld, w_ic_vld_nxt;
    logic              r_dc_vld, w_dc_vld_nxt;
    logic              r_rsp_last, w_rsp_last_nxt;
    logic [IDX_W-1:0]  r_rsp_word, w_rsp_word_nxt;

    logic              w_ic_ack, w_dc_ack, w_rd_beat;
    logic [ADDR_W-1:0] w_req_addr;
    logic [IDX_W-1:0]  w_start, w_idx_inc;
    logic              w_unused;

    // dcache has fixed priority; acks are suppressed while reset is held
    assign w_dc_ack   = (r_state == ST_IDLE) && bus.dc_req && RST_cpu_n;
    assign w_ic_ack   = (r_state == ST_IDLE) && bus.ic_req && !bus.dc_req && RST_cpu_n;
    assign w_req_addr = bus.dc_req ? bus.dc_addr : bus.ic_addr;
    assign w_idx_inc  = r_ram_addr[IDX_W-1:0] + IDX_W'(1);
    assign w_rd_beat  = r_ram_en && !r_ram_we;
    assign w_unused   = ^{bus.ic_addr[1:0], bus.dc_addr[1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = w_req_addr[IDX_W+1:2];
`else
    assign w_start = '0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_src_dc_nxt    = r_src_dc;
        w_beat_nxt      = r_beat;
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_wstrb_nxt = '0;
        w_ram_wdata_nxt = '0;
        w_ram_addr_nxt  = r_ram_addr;

        case (r_state)
            ST_IDLE: begin
                if (w_dc_ack && bus.dc_we) begin
                    w_state_nxt     = ST_WRITE;
                    w_src_dc_nxt    = 1'b1;
                    w_ram_en_nxt    = 1'b1;
                    w_ram_we_nxt    = 1'b1;
                    w_ram_wstrb_nxt = bus.dc_wstrb;
                    w_ram_wdata_nxt = bus.dc_wdata;
                    w_ram_addr_nxt  = bus.dc_addr[ADDR_W-1:2];
                end else if (w_dc_ack || w_ic_ack) begin
                    w_state_nxt    = ST_READ;
                    w_src_dc_nxt   = w_dc_ack;
                    w_beat_nxt     = '0;
                    w_ram_en_nxt   = 1'b1;
                    w_ram_addr_nxt = {w_req_addr[ADDR_W-1:IDX_W+2], w_start};
                end
            end
            ST_READ: begin
                if (r_beat == LAST_BEAT) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_beat_nxt     = r_beat + IDX_W'(1);
                    w_ram_en_nxt   = 1'b1;
                    // index wraps inside the line; the line base never carries
                    w_ram_addr_nxt = {r_ram_addr[WA_W-1:IDX_W], w_idx_inc};
                end
            end
            ST_DRAIN: w_state_nxt = ST_IDLE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        // response stage mirrors the read issued one cycle earlier
        w_ic_vld_nxt   = w_rd_beat && !r_src_dc;
        w_dc_vld_nxt   = w_rd_beat && r_src_dc;
        w_rsp_last_nxt = w_rd_beat && (r_beat == LAST_BEAT);
        w_rsp_word_nxt = w_rd_beat ? r_ram_addr[IDX_W-1:0] : '0;
    end

    always_ff @(posedge CLK_cpu or negedge RST_cpu_n) begin
        if (!RST_cpu_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK_cpu or negedge RST_cpu_n) begin
        if (!RST_cpu_n) begin
            r_src_dc    <= 1'b0;
            r_beat      <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_wstrb <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ic_vld    <= 1'b0;
            r_dc_vld    <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_word  <= '0;
        end else begin
            r_src_dc    <= w_src_dc_nxt;
            r_beat      <= w_beat_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_wstrb <= w_ram_wstrb_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_ic_vld    <= w_ic_vld_nxt;
            r_dc_vld    <= w_dc_vld_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_rsp_word  <= w_rsp_word_nxt;
        end
    end

    assign bus.ic_ack       = w_ic_ack;
    assign bus.dc_ack       = w_dc_ack;
    assign bus.ic_rsp_valid = r_ic_vld;
    assign bus.dc_rsp_valid = r_dc_vld;
    assign bus.rsp_data     = (r_ic_vld || r_dc_vld) ? bus.ram_rdata : 32'h0;
    assign bus.rsp_word     = r_rsp_word;
    assign bus.rsp_last     = r_rsp_last;
    assign bus.ram_en       = r_ram_en;
    assign bus.ram_we       = r_ram_we;
    assign bus.ram_wstrb    = r_ram_wstrb;
    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_wdata    = r_ram_wdata;
    assign bus.busy         = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mem_refill_responder.sv
// Directed bench for mem_refill_responder: fetches, arbitration, stores, line-top wrap and mid-burst reset.
module tb_mem_refill_responder;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_refill_responder_if #(.ADDR_W(20), .WORDS_PER_LINE(N)) bus ();

    mem_refill_responder #(.ADDR_W(20), .WORDS_PER_LINE(N)) dut (
        .CLK_cpu   (clk),
        .RST_cpu_n (rst_n),
        .bus       (bus)
    );

    // RAM returns a word derived from its word address one cycle after a read strobe
    always @(posedge clk) begin
        if (bus.ram_en && !bus.ram_we)
            bus.ram_rdata <= 32'h5A000000 | 32'(bus.ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ack(input bit dc, output bit got);
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = dc ? bus.dc_ack : bus.ic_ack;
        end
    endtask

    // base = expected line base word address (low index bits zero)
    task automatic fetch(input bit dc, input logic [19:0] addr, input logic [17:0] base,
                         input bit also_ic);
        bit got;
        int st, wi;
`ifdef CRITICAL_WORD_FIRST_EN
        st = int'(addr[3:2]);
`else
        st = 0;
`endif
        @(posedge clk); #1;
        if (also_ic) begin bus.ic_req = 1'b1; bus.ic_addr = 20'h00200; end
        if (dc) begin bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = addr; end
        else begin bus.ic_req = 1'b1; bus.ic_addr = addr; end
        wait_ack(dc, got);
        check("fetch_ack", 32'(got), 32'd1);
        check("fetch_other_ack", 32'(dc ? bus.ic_ack : bus.dc_ack), 32'd0);
        check("fetch_idle_at_T", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        if (dc) bus.dc_req = 1'b0; else bus.ic_req = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            check("burst_busy", 32'(bus.busy), 32'd1);
            check("burst_ram_en", 32'(bus.ram_en), 32'(k <= N));
            check("burst_ram_we", 32'(bus.ram_we), 32'd0);
            if (k <= N)
                check("burst_ram_addr", 32'(bus.ram_addr), 32'(base) + 32'((st + k - 1) % N));
            if (k == 1) begin
                check("ack_pulse", 32'(dc ? bus.dc_ack : bus.ic_ack), 32'd0);
                check("no_early_vld", 32'({bus.ic_rsp_valid, bus.dc_rsp_valid}), 32'd0);
            end else begin
                wi = (st + k - 2) % N;
                check("beat_vld", 32'(dc ? bus.dc_rsp_valid : bus.ic_rsp_valid), 32'd1);
                check("beat_other_vld", 32'(dc ? bus.ic_rsp_valid : bus.dc_rsp_valid), 32'd0);
                check("beat_word", 32'(bus.rsp_word), 32'(wi));
                check("beat_data", bus.rsp_data, 32'h5A000000 | (32'(base) + 32'(wi)));
                check("beat_last", 32'(bus.rsp_last), 32'(k == N + 1));
            end
        end
        @(negedge clk);
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_vld", 32'({bus.ic_rsp_valid, bus.dc_rsp_valid, bus.rsp_last, bus.ram_en}), 32'd0);
    endtask

    task automatic store(input logic [19:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [17:0] exp_waddr);
        bit got;
        @(posedge clk); #1;
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = addr;
        bus.dc_wdata = wd; bus.dc_wstrb = ws;
        wait_ack(1'b1, got);
        check("st_ack", 32'(got), 32'd1);
        check("st_en_at_T", 32'(bus.ram_en), 32'd0);
        @(posedge clk); #1;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_wdata = '0; bus.dc_wstrb = '0;
        @(negedge clk);
        check("st_ram_en", 32'(bus.ram_en), 32'd1);
        check("st_ram_we", 32'(bus.ram_we), 32'd1);
        check("st_ram_addr", 32'(bus.ram_addr), 32'(exp_waddr));
        check("st_wstrb", 32'(bus.ram_wstrb), 32'(ws));
        check("st_wdata", bus.ram_wdata, wd);
        check("st_busy", 32'(bus.busy), 32'd1);
        check("st_no_vld", 32'({bus.ic_rsp_valid, bus.dc_rsp_valid}), 32'd0);
        @(negedge clk);
        check("st_done_busy", 32'(bus.busy), 32'd0);
        check("st_done_en", 32'({bus.ram_en, bus.ram_we, bus.dc_rsp_valid}), 32'd0);
    endtask

    initial begin
        bit got;
        int nb;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0;
        bus.dc_wdata = '0; bus.dc_wstrb = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ram", 32'({bus.ram_en, bus.ram_we, bus.ram_wstrb}), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_rsp", 32'({bus.ic_rsp_valid, bus.dc_rsp_valid, bus.rsp_last, bus.rsp_word}), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // plain icache fetch, line 0x48
        fetch(1'b0, 20'h00124, 18'h00048, 1'b0);

        // simultaneous requests: dcache wins, icache served at T+N+2
        fetch(1'b1, 20'h00400, 18'h00100, 1'b1);
        check("arb_ic_ack_late", 32'(bus.ic_ack), 32'd1);
        @(posedge clk); #1 bus.ic_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = !bus.busy;
        end
        check("arb_ic_done", 32'(got), 32'd1);

        // stores
        store(20'h00013, 32'hAB000000, 4'b1000, 18'h00004);
        store(20'h00102, 32'h12340000, 4'b1100, 18'h00040);

        // critical-word case (order depends on build)
        fetch(1'b1, 20'h0002C, 18'h00008, 1'b0);

        // top line of memory, no carry
        fetch(1'b0, 20'hFFFF0, 18'h3FFFC, 1'b0);

        // reset during the second data beat
        @(posedge clk); #1;
        bus.ic_req = 1'b1; bus.ic_addr = 20'h00100;
        wait_ack(1'b0, got);
        check("rstb_ack", 32'(got), 32'd1);
        @(posedge clk); #1 bus.ic_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rstb_pre_vld", 32'(bus.ic_rsp_valid), 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstb_busy", 32'(bus.busy), 32'd0);
        check("rstb_ram", 32'({bus.ram_en, bus.ram_we}), 32'd0);
        check("rstb_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rstb_rsp", 32'({bus.ic_rsp_valid, bus.dc_rsp_valid, bus.rsp_last, bus.rsp_word}), 32'd0);
        check("rstb_rsp_data", bus.rsp_data, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ic_rsp_valid || bus.dc_rsp_valid || bus.ram_en || bus.busy) nb++;
        end
        check("rstb_no_beats", 32'(nb), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
